mem_access_unit: RTL and testbench

MEM-stage access unit between the EX/MEM pipeline register and the word-addressed data memory. Converts MIPS byte/halfword/word loads and stores (lb, lbu, lh, lhu, sb, sh, sw, lw) into whole-word memory accesses. Sub-word stores use a two-cycle read-modify-write and stall the pipeline for one cycle. Loads are extracted and sign- or zero-extended with zero latency.

---
 rtl/mem_access_unit_pkg.sv | 55 +++++
 rtl/mem_access_unit_if.sv | 38 +++
 rtl/mem_access_unit_lane_merge.sv | 37 +++
 rtl/mem_access_unit.sv | 109 ++++++++++
 tb/tb_mem_access_unit.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MEM-stage access unit: size codes, FSM states, lane constants
// and small helpers for lane selection and alignment checking.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_e;

  localparam logic [1:0] LANE_LO      = 2'b00;
  localparam logic [1:0] LANE_HALF_HI = 2'b10;

  typedef struct packed {
    logic [29:0] idx;
    logic [1:0]  lane;
    size_e       size;
    logic [31:0] data;
  } capture_t;

  // The reserved size code behaves exactly like a word access.
  function automatic size_e norm_size(input logic [1:0] sz);
    size_e r;
    r = (sz == SZ_RSVD) ? SZ_WORD : size_e'(sz);
    return r;
  endfunction

  // Low address bits below the access size are dropped, force-aligning the lane.
  function automatic logic [1:0] lane_of(input logic [1:0] a, input size_e sz);
    logic [1:0] l;
    case (sz)
      SZ_BYTE: l = a;
      SZ_HALF: l = a[1] ? LANE_HALF_HI : LANE_LO;
      default: l = LANE_LO;
    endcase
    return l;
  endfunction

  function automatic logic misaligned(input logic [1:0] a, input size_e sz);
    logic m;
    case (sz)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = a[0];
      default: m = (a != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline/memory-side bus of the access unit. With MEM_MISALIGN_TRAP_EN defined the
// bus also carries misalign and misalign_seen.
interface mem_access_unit_if;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] load_data;
  logic        stall;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
  logic        misalign_seen;

  modport slave (
    input  mem_read, mem_write, size, sign_ext, addr, store_data, mem_rdata,
    output mem_addr, mem_wdata, mem_we, load_data, stall, misalign, misalign_seen
  );
  modport master (
    output mem_read, mem_write, size, sign_ext, addr, store_data, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, load_data, stall, misalign, misalign_seen
  );
`else
  modport slave (
    input  mem_read, mem_write, size, sign_ext, addr, store_data, mem_rdata,
    output mem_addr, mem_wdata, mem_we, load_data, stall
  );
  modport master (
    output mem_read, mem_write, size, sign_ext, addr, store_data, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, load_data, stall
  );
`endif
endinterface

// File: rtl/mem_access_unit_lane_merge.sv
// Combinational lane logic: insert_i=0 extracts and extends a lane of word_i,
// insert_i=1 replaces that lane of word_i with the low bits of op_data_i.
module mem_lane_merge
  import mem_pkg::*;
(
  input  logic        insert_i,
  input  size_e       size_i,
  input  logic [1:0]  lane_i,
  input  logic        sign_ext_i,
  input  logic [31:0] word_i,
  input  logic [31:0] op_data_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{lane_i, 3'b000} +: 8];
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
    result_o = word_i;
    if (insert_i) begin
      case (size_i)
        SZ_BYTE: result_o[{lane_i, 3'b000} +: 8]     = op_data_i[7:0];
        SZ_HALF: result_o[{lane_i[1], 4'b0000} +: 16] = op_data_i[15:0];
        default: result_o = op_data_i;
      endcase
    end else begin
      case (size_i)
        SZ_BYTE: result_o = {{24{sign_ext_i & byte_sel[7]}}, byte_sel};
        SZ_HALF: result_o = {{16{sign_ext_i & half_sel[15]}}, half_sel};
        default: result_o = word_i;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: zero-latency extending loads, single-cycle word stores and
// two-cycle read-modify-write sub-word stores. Optional trap: MEM_MISALIGN_TRAP_EN.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus
);

  state_e      state_q, state_d;
  capture_t    cap_q, cap_d;
  logic [31:0] merge_q, merge_d;
  size_e       sz;
  logic [1:0]  lane;
  logic        is_load, is_store, bad;
  logic [31:0] load_word, merged_word;

  assign sz       = norm_size(bus.size);
  assign lane     = lane_of(bus.addr[1:0], sz);
  assign is_store = bus.mem_write;
  assign is_load  = bus.mem_read & ~bus.mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
  logic seen_q;
  assign bad = ~rst & (state_q == IDLE) & (is_load | is_store) & misaligned(bus.addr[1:0], sz);
  assign bus.misalign      = bad;
  assign bus.misalign_seen = seen_q;

  always_ff @(posedge clk) begin
    if (rst)      seen_q <= 1'b0;
    else if (bad) seen_q <= 1'b1;
  end
`else
  assign bad = 1'b0;
`endif

  mem_lane_merge u_load (
    .insert_i   (1'b0),
    .size_i     (sz),
    .lane_i     (lane),
    .sign_ext_i (bus.sign_ext),
    .word_i     (bus.mem_rdata),
    .op_data_i  (32'h0),
    .result_o   (load_word)
  );

  mem_lane_merge u_store (
    .insert_i   (1'b1),
    .size_i     (cap_q.size),
    .lane_i     (cap_q.lane),
    .sign_ext_i (1'b0),
    .word_i     (merge_q),
    .op_data_i  (cap_q.data),
    .result_o   (merged_word)
  );

  always_comb begin
    bus.mem_addr  = {2'b00, bus.addr[31:2]};
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    bus.load_data = '0;
    bus.stall     = 1'b0;
    state_d       = state_q;
    cap_d         = cap_q;
    merge_d       = merge_q;
    if (state_q == MERGE) begin
      // Held instruction on the inputs is ignored; only the captured store completes.
      bus.mem_addr  = {2'b00, cap_q.idx};
      bus.mem_wdata = merged_word;
      bus.mem_we    = 1'b1;
      state_d       = IDLE;
    end else if (!bad) begin
      if (is_load) begin
        bus.load_data = load_word;
      end else if (is_store && sz == SZ_WORD) begin
        bus.mem_we    = 1'b1;
        bus.mem_wdata = bus.store_data;
      end else if (is_store) begin
        bus.stall  = 1'b1;
        cap_d.idx  = bus.addr[31:2];
        cap_d.lane = lane;
        cap_d.size = sz;
        cap_d.data = bus.store_data;
        merge_d    = bus.mem_rdata;
        state_d    = MERGE;
      end
    end
    if (rst) begin
      bus.mem_we    = 1'b0;
      bus.mem_wdata = '0;
      bus.load_data = '0;
      bus.stall     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cap_q   <= '0;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      merge_q <= merge_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table of load vectors, hand sequences for store corner
// cases, and randomized traffic against a byte-arithmetic reference memory.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if bus ();
  mem_access_unit dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] mem [0:2047];
  logic        poke_en = 1'b0;
  logic [10:0] poke_a  = '0;
  logic [31:0] poke_d  = '0;

  assign bus.mem_rdata = mem[bus.mem_addr[10:0]];
  always @(posedge clk) begin
    if (bus.mem_we)   mem[bus.mem_addr[10:0]] <= bus.mem_wdata;
    else if (poke_en) mem[poke_a] <= poke_d;
  end

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] ref_mem [0:15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    bus.mem_read = rd; bus.mem_write = wr; bus.size = sz;
    bus.sign_ext = sx; bus.addr = a; bus.store_data = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    @(negedge clk);
    idle();
    poke_a = a[10:0]; poke_d = d; poke_en = 1'b1;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                          input logic sx, input int a);
    int n = nbytes(sz);
    int off = (a % 4) - ((a % 4) % n);
    longint v = (longint'(w) >> (8 * off)) & ((64'd1 << (8 * n)) - 1);
    if (sx && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [31:0] d, input int a);
    int n = nbytes(sz);
    int off = (a % 4) - ((a % 4) % n);
    longint mask = ((64'd1 << (8 * n)) - 1) << (8 * off);
    longint r = (longint'(w) & ~mask) | ((longint'(d) << (8 * off)) & mask);
    return r[31:0];
  endfunction

  typedef struct {
    logic        rd, wr;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] exp_load;
    logic [31:0] exp_maddr;
  } vec_t;
  vec_t tbl [10];

  task automatic rand_op();
    logic rd, wr, sx, mis, exp_stall;
    logic [1:0] sz;
    logic [31:0] d, exp_ld;
    int a, w, n;
    rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
    sz = 2'($urandom_range(0, 3)); sx = 1'($urandom_range(0, 1));
    a = $urandom_range(0, 63); d = $urandom; w = a / 4; n = nbytes(sz);
    mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = (rd | wr) && (a % n != 0);
`endif
    exp_stall = wr && n < 4 && !mis;
    exp_ld = (rd && !wr && !mis) ? ref_load(ref_mem[w], sz, sx, a) : 32'h0;
    @(negedge clk);
    drive(rd, wr, sz, sx, a, d);
    #1;
    check("rnd_stall", {31'b0, bus.stall}, {31'b0, exp_stall});
    check("rnd_load", bus.load_data, exp_ld);
`ifdef MEM_MISALIGN_TRAP_EN
    check("rnd_misalign", {31'b0, bus.misalign}, {31'b0, mis});
`endif
    if (exp_stall) begin
      @(negedge clk);
      #1 check("rnd_merge_we", {31'b0, bus.mem_we}, 32'd1);
    end
    if (wr && !mis) ref_mem[w] = ref_store(ref_mem[w], sz, d, a);
    @(negedge clk);
    idle();
    #1 check("rnd_mem", mem[w], ref_mem[w]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'd4004, 32'h5555_5555);
    // Reset: outputs quiet even with a store and a load presented.
    @(negedge clk); #1;
    check("rst_we", {31'b0, bus.mem_we}, 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    check("rst_stall", {31'b0, bus.stall}, 32'd0);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'd4004, 32'h0);
    #1 check("rst_load", bus.load_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();

    poke(250, 32'h8070_60F0);
    poke(1001, 32'h1122_3344);
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      poke(i, ref_mem[i]);
    end

    tbl[0] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'd1000, 32'hFFFF_FFF0, 32'd250};
    tbl[1] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'd1003, 32'h0000_0080, 32'd250};
    tbl[2] = '{1'b1, 1'b0, 2'b01, 1'b1, 32'd1002, 32'hFFFF_8070, 32'd250};
    tbl[3] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'd1000, 32'h0000_60F0, 32'd250};
    tbl[4] = '{1'b1, 1'b0, 2'b01, 1'b1, 32'd1000, 32'h0000_60F0, 32'd250};
    tbl[5] = '{1'b1, 1'b0, 2'b10, 1'b1, 32'd1000, 32'h8070_60F0, 32'd250};
    tbl[6] = '{1'b1, 1'b0, 2'b11, 1'b1, 32'd1000, 32'h8070_60F0, 32'd250};
    tbl[7] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'd1001, 32'h0000_0060, 32'd250};
    tbl[8] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'd1002, 32'h0000_0070, 32'd250};
    tbl[9] = '{1'b0, 1'b0, 2'b10, 1'b1, 32'd1000, 32'h0000_0000, 32'd250};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].sx, tbl[i].addr, 32'hFFFF_FFFF);
      #1;
      check($sformatf("tbl%0d_load", i), bus.load_data, tbl[i].exp_load);
      check($sformatf("tbl%0d_addr", i), bus.mem_addr, tbl[i].exp_maddr);
      check($sformatf("tbl%0d_we", i), {31'b0, bus.mem_we}, 32'd0);
      check($sformatf("tbl%0d_stall", i), {31'b0, bus.stall}, 32'd0);
    end

    // Word store writes in the request cycle.
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'd4004, 32'h1234_5678);
    #1;
    check("sw_we", {31'b0, bus.mem_we}, 32'd1);
    check("sw_addr", bus.mem_addr, 32'd1001);
    check("sw_wdata", bus.mem_wdata, 32'h1234_5678);
    check("sw_stall", {31'b0, bus.stall}, 32'd0);
    @(negedge clk); idle();
    #1 check("sw_mem", mem[1001], 32'h1234_5678);
    poke(1001, 32'h1122_3344);

    // Byte store: read cycle with stall, then merged write.
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'd4005, 32'hFFFF_FFAB);
    #1;
    check("sb_n_stall", {31'b0, bus.stall}, 32'd1);
    check("sb_n_we", {31'b0, bus.mem_we}, 32'd0);
    @(negedge clk); #1;
    check("sb_n1_we", {31'b0, bus.mem_we}, 32'd1);
    check("sb_n1_stall", {31'b0, bus.stall}, 32'd0);
    check("sb_n1_addr", bus.mem_addr, 32'd1001);
    check("sb_n1_wdata", bus.mem_wdata, 32'h1122_AB44);
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'd4004, 32'h0);
    #1 check("sb_lw", bus.load_data, 32'h1122_AB44);

    // Reset during the merge cycle of a halfword store aborts the write.
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'd4006, 32'h0000_BEEF);
    #1 check("sh_stall", {31'b0, bus.stall}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1 check("sh_rst_we", {31'b0, bus.mem_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1 check("sh_rst_mem", mem[1001], 32'h1122_AB44);
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'd4004, 32'h0);
    #1;
    check("sh_rst_idle_load", bus.load_data, 32'h1122_AB44);
    check("sh_rst_idle_we", {31'b0, bus.mem_we}, 32'd0);

    // Back-to-back byte stores stay coherent.
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'd4004, 32'h0000_0011);
    @(negedge clk); #1 check("b2b_w1", bus.mem_wdata, 32'h1122_AB11);
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'd4007, 32'h0000_0022);
    #1 check("b2b_stall2", {31'b0, bus.stall}, 32'd1);
    @(negedge clk); #1 check("b2b_w2", bus.mem_wdata, 32'h2222_AB11);
    @(negedge clk); idle();
    #1 check("b2b_mem", mem[1001], 32'h2222_AB11);

    // Read and write together behave as a store.
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b10, 1'b1, 32'd4004, 32'hCAFE_F00D);
    #1;
    check("rdwr_we", {31'b0, bus.mem_we}, 32'd1);
    check("rdwr_load", bus.load_data, 32'd0);
    @(negedge clk); idle();
    #1 check("rdwr_mem", mem[1001], 32'hCAFE_F00D);

    // Misaligned word load.
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'd4006, 32'h0);
    #1;
`ifdef MEM_MISALIGN_TRAP_EN
    check("mis_flag", {31'b0, bus.misalign}, 32'd1);
    check("mis_we", {31'b0, bus.mem_we}, 32'd0);
    check("mis_load", bus.load_data, 32'd0);
    @(negedge clk); idle();
    #1 check("mis_seen", {31'b0, bus.misalign_seen}, 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'd4005, 32'h1);
    #1 check("mis_sh_stall", {31'b0, bus.stall}, 32'd0);
    @(negedge clk); idle();
    #1 check("mis_seen_hold", {31'b0, bus.misalign_seen}, 32'd1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1 check("mis_seen_clr", {31'b0, bus.misalign_seen}, 32'd0);
`else
    check("mis_load", bus.load_data, 32'hCAFE_F00D);
    check("mis_addr", bus.mem_addr, 32'd1001);
`endif

    for (int i = 0; i < 300; i++) rand_op();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
